// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode predicates for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_MULHU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_REM   = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // 1000, 1001 and 11xx run through the shift datapath; 1010/1011 are unknown.
  function automatic logic is_iterative(input logic [3:0] sl);
    return sl[3] & (sl[2] | ~sl[1]);
  endfunction

  function automatic logic is_divide(input logic [3:0] sl);
    return sl[3] & sl[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider with sign fix-up.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       sl,
  output logic             last,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_signed, w_neg1, w_neg2;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;

  assign w_signed = (sl == ALU_DIV) || (sl == ALU_REM);
  assign w_neg1   = w_signed & in1[WIDTH-1];
  assign w_neg2   = w_signed & in2[WIDTH-1];
  assign w_mag1   = w_neg1 ? -in1 : in1;
  assign w_mag2   = w_neg2 ? -in2 : in2;

  // r_opnd holds the multiplicand for multiplies, the divisor magnitude for divides.
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd & {WIDTH{r_acc[0]}}};
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_opnd};
  assign w_fits  = ~w_trial[WIDTH];

  assign last = step && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (load) begin
      r_op    <= sl;
      r_acc   <= {{WIDTH{1'b0}}, in2};
      r_opnd  <= is_divide(sl) ? w_mag2 : in1;
      r_quo   <= w_mag1;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end else if (step) begin
      r_cnt <= r_cnt + 1'b1;
      if (is_divide(r_op)) begin
        r_rem <= w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        r_quo <= {r_quo[WIDTH-2:0], w_fits};
      end else begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    result = '0;
    case (r_op)
      ALU_MUL:             result = r_acc[WIDTH-1:0];
      ALU_MULHU:           result = r_acc[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:   result = r_neg_q ? -r_quo : r_quo;
      ALU_REM, ALU_REMU:   result = r_neg_r ? -r_rem : r_rem;
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative MUL/MULHU/DIV/REM
// behind an IDLE/RUN/FIX controller with a registered result and done pulse.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       sl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             sign
);
  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_out, w_out_next;
  logic             r_done, w_done_next;
  logic             w_iter_load, w_step, w_last;
  logic [WIDTH-1:0] w_simple, w_iter_result;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (w_iter_load),
    .step   (w_step),
    .in1    (in1),
    .in2    (in2),
    .sl     (sl),
    .last   (w_last),
    .result (w_iter_result)
  );

  assign w_step = (r_state == ST_RUN);

  // Divide-by-zero results are produced here so they complete in one cycle.
  always_comb begin
    w_simple = '0;
    case (sl)
      ALU_ADD:           w_simple = in1 + in2;
      ALU_SUB:           w_simple = in1 - in2;
      ALU_AND:           w_simple = in1 & in2;
      ALU_OR:            w_simple = in1 | in2;
      ALU_XOR:           w_simple = in1 ^ in2;
      ALU_SLT:           w_simple = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_SLTU:          w_simple = {{(WIDTH-1){1'b0}}, in1 < in2};
      ALU_DIV, ALU_DIVU: w_simple = '1;
      ALU_REM, ALU_REMU: w_simple = in1;
      default:           w_simple = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    w_done_next  = 1'b0;
    w_iter_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_iterative(sl) && !(is_divide(sl) && (in2 == '0))) begin
            w_iter_load  = 1'b1;
            w_state_next = ST_RUN;
          end else begin
            w_out_next  = w_simple;
            w_done_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_last) w_state_next = ST_FIX;
      end
      ST_FIX: begin
        w_out_next   = w_iter_result;
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_done  <= w_done_next;
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign out  = r_out;
  assign zero = (r_out == '0);
  assign sign = r_out[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// Directed vector bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [3:0]  sl = '0;

  logic        busy32, done32, zero32, sign32;
  logic [31:0] out32;
  logic        busy8, done8, zero8, sign8;
  logic [7:0]  out8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .in1(in1), .in2(in2), .sl(sl),
    .busy(busy32), .done(done32), .out(out32), .zero(zero32), .sign(sign32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in1(in1[7:0]), .in2(in2[7:0]), .sl(sl),
    .busy(busy8), .done(done8), .out(out8), .zero(zero8), .sign(sign8)
  );

  typedef struct {
    logic        w8;
    logic [3:0]  sl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t v [27];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic cur_done(input logic w8);
    return w8 ? done8 : done32;
  endfunction
  function automatic logic cur_busy(input logic w8);
    return w8 ? busy8 : busy32;
  endfunction
  function automatic logic [31:0] cur_out(input logic w8);
    return w8 ? {24'd0, out8} : out32;
  endfunction

  task automatic run_op(input vec_t t, input int idx);
    int lat, busyc;
    logic [31:0] got;
    logic        zexp, sexp;
    @(negedge clk);
    sl = t.sl; in1 = t.a; in2 = t.b;
    if (t.w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    lat = 1; busyc = 0;
    while (!cur_done(t.w8) && lat < 200) begin
      if (cur_busy(t.w8)) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    got  = cur_out(t.w8);
    zexp = (t.exp == 32'd0);
    sexp = t.w8 ? t.exp[7] : t.exp[31];
    $display("vec %0d w8=%0b sl=%b a=%h b=%h out=%h lat=%0d busy_cycles=%0d",
             idx, t.w8, t.sl, t.a, t.b, got, lat, busyc);
    check($sformatf("v%0d latency", idx), lat, t.lat);
    check($sformatf("v%0d busy_cycles", idx), busyc, (t.lat > 1) ? t.lat - 1 : 0);
    check($sformatf("v%0d busy_in_done", idx), {31'd0, cur_busy(t.w8)}, 32'd0);
    check($sformatf("v%0d out", idx), got, t.exp);
    check($sformatf("v%0d zero", idx), {31'd0, t.w8 ? zero8 : zero32}, {31'd0, zexp});
    check($sformatf("v%0d sign", idx), {31'd0, t.w8 ? sign8 : sign32}, {31'd0, sexp});
  endtask

  initial begin
    int lat, busyc, dcount;

    v[0]  = '{1'b0, ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
    v[1]  = '{1'b0, ALU_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1};
    v[2]  = '{1'b0, ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    v[3]  = '{1'b0, ALU_OR,    32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1};
    v[4]  = '{1'b0, ALU_XOR,   32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1};
    v[5]  = '{1'b0, ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    v[6]  = '{1'b0, ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    v[7]  = '{1'b0, 4'b0111,   32'h12345678, 32'h11111111, 32'h00000000, 1};
    v[8]  = '{1'b0, 4'b1010,   32'h12345678, 32'h11111111, 32'h00000000, 1};
    v[9]  = '{1'b0, ALU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34};
    v[10] = '{1'b0, ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    v[11] = '{1'b0, ALU_MUL,   32'h00012345, 32'h00000064, 32'h0071C6F4, 34};
    v[12] = '{1'b0, ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
    v[13] = '{1'b0, ALU_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
    v[14] = '{1'b0, ALU_DIVU,  32'h00000064, 32'h00000007, 32'h0000000E, 34};
    v[15] = '{1'b0, ALU_REMU,  32'h00000064, 32'h00000007, 32'h00000002, 34};
    v[16] = '{1'b0, ALU_DIVU,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    v[17] = '{1'b0, ALU_REM,   32'h00000005, 32'h00000000, 32'h00000005, 1};
    v[18] = '{1'b0, ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
    v[19] = '{1'b0, ALU_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
    v[20] = '{1'b0, ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    v[21] = '{1'b0, ALU_REM,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34};
    v[22] = '{1'b1, ALU_MULHU, 32'h000000FF, 32'h000000FF, 32'h000000FE, 10};
    v[23] = '{1'b1, ALU_MUL,   32'h000000FF, 32'h000000FF, 32'h00000001, 10};
    v[24] = '{1'b1, ALU_DIV,   32'h000000F9, 32'h00000002, 32'h000000FD, 10};
    v[25] = '{1'b1, ALU_DIV,   32'h00000080, 32'h000000FF, 32'h00000080, 10};
    v[26] = '{1'b1, ALU_REM,   32'h00000080, 32'h000000FF, 32'h00000000, 10};

    #1;
    check("reset busy", {31'd0, busy32}, 32'd0);
    check("reset done", {31'd0, done32}, 32'd0);
    check("reset out", out32, 32'd0);
    check("reset zero", {31'd0, zero32}, 32'd1);
    check("reset sign", {31'd0, sign32}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) run_op(v[i], i);

    // Starts while busy are ignored; operand changes after the start edge too.
    @(negedge clk);
    sl = ALU_DIVU; in1 = 32'd100; in2 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1; busyc = 0;
    while (!done32 && lat < 200) begin
      if (busy32) busyc++;
      start32 = (lat % 3 == 1);
      sl = ALU_ADD; in1 = lat; in2 = 32'd1;
      @(posedge clk); #1;
      lat++;
    end
    start32 = 1'b0;
    $display("busy-ignore DIVU 100/7 out=%h lat=%0d", out32, lat);
    check("ignore latency", lat, 34);
    check("ignore busy_cycles", busyc, 33);
    check("ignore out", out32, 32'h0000000E);

    // Start issued in the done cycle is accepted back-to-back.
    run_op(v[10], 100);
    sl = ALU_ADD; in1 = 32'd2; in2 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    $display("back-to-back ADD 2+3 done=%0b out=%h", done32, out32);
    check("b2b done", {31'd0, done32}, 32'd1);
    check("b2b out", out32, 32'd5);
    @(posedge clk); #1;
    check("b2b done pulse end", {31'd0, done32}, 32'd0);

    // Reset mid-RUN aborts the operation with no later done.
    @(negedge clk);
    sl = ALU_MUL; in1 = 32'hFFFFFFFF; in2 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort busy before rst", {31'd0, busy32}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy32}, 32'd0);
    check("abort done", {31'd0, done32}, 32'd0);
    check("abort out", out32, 32'd0);
    check("abort zero", {31'd0, zero32}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done32) dcount++;
    end
    $display("abort MUL: done pulses after reset=%0d", dcount);
    check("abort no done", dcount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the multi-cycle and pipelined CPU variants. It keeps the single-cycle integer operations (add, sub, and, or, xor, slt, sltu) and adds iterative multiply, divide and remainder (RV32M semantics). Operands are captured on a start strobe. The result is returned registered with a one-cycle done pulse, so the controller FSM can stall on busy instead of assuming fixed latency.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled at a rising edge only while busy=0.
- in1  in  WIDTH  first operand (dividend / multiplicand).
- in2  in  WIDTH  second operand (divisor / multiplier).
- sl  in  4  operation select:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU.
  - 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned).
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
  - Any other code: result 0.
- busy  out  1  operation in progress; start is ignored while busy=1.
- done  out  1  one-cycle pulse; out is valid from this cycle onward.
- out  out  WIDTH  registered result; holds until the next done.
- zero  out  1  combinational: out == 0.
- sign  out  1  combinational: out[WIDTH-1].

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + start:
  - Latch in1, in2 and sl; later input changes have no effect.
  - Simple op, unknown code, or divide with in2 == 0: compute the result, load out, pulse done, stay in IDLE.
  - MUL/MULHU/DIV/DIVU/REM/REMU with nonzero divisor: set busy, clear the iteration counter, go to RUN.
- RUN takes exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator; both operands unsigned.
  - Divide: restoring division on magnitudes. For DIV/REM, negative operands are negated first and their signs recorded.
  - Counter reaches WIDTH-1 → FIX.
- FIX:
  - Select the low or high product half, or the quotient or remainder.
  - Apply sign correction: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Load out, pulse done, clear busy, go to IDLE.
- Divide by zero: DIV/DIVU → all ones; REM/REMU → in1.
- Signed overflow, min / −1: DIV → min, REM → 0. This falls out of the magnitude path; no special case.
- SLT is signed compare; SLTU is unsigned. Both produce 0 or 1.
- ADD, SUB and MUL wrap modulo 2^WIDTH; there are no carry or overflow flags.

## Timing
- Reset values (asynchronous, immediate): state IDLE, busy 0, done 0, out 0, hence zero 1 and sign 0. All internal registers are cleared.
- Latency, counted from the start edge E:
  - Simple ops, unknown codes, divide by zero: done high in cycle E+1.
  - Iterative ops: busy high over cycles E+1 … E+WIDTH+1; done high in cycle E+WIDTH+2, with busy low in that same cycle.
- done is never high for more than one consecutive cycle unless a new start is accepted in its cycle.
- start while busy=1 is ignored: no queuing, no error.
- start in the done cycle is accepted (busy=0 then), giving back-to-back operations.
- Reset mid-RUN or mid-FIX aborts the operation. No done is produced for the aborted op.
- out changes only in a done cycle, or on reset.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit opcode localparams (ALU_ADD … ALU_REMU);
  - the state encoding;
  - a helper predicate is_iterative(sl).
- Sub-module alu_muldiv_iter (WIDTH parameter) holds the RUN datapath: accumulator, quotient/remainder registers, counter.
- Simple ops and the FSM stay in alu_mc.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → out 0x80000000, sign 1, zero 0, done in E+1. SUB 5 − 5 → out 0, zero 1.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001. MULHU on the same operands → 0xFFFFFFFE. done exactly in E+34, with busy high for the 33 cycles before.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 0x0000000E. REMU 100/7 → 0x00000002.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 0x00000005, both done in E+1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM on the same operands → 0.
- Handshake and control:
  - start pulses during busy are ignored, and the result matches the first op.
  - A start in the done cycle is accepted.
  - rst asserted mid-RUN → busy 0, done 0, out 0, zero 1 immediately, and no later done.
- Repeat the MUL and DIV cases with WIDTH=8: 0xFF × 0xFF MULHU → 0xFE, latency E+10.
